// File: rtl/dmem_responder.sv
// dmem_responder: RV32I load/store responder with fixed latency, lane selection, extension and misalignment errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic we_q;
    logic [2:0] f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic req_ready_q, resp_valid_q, resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, commit, we, bad;
    logic [2:0] f3;
    logic [AW+1:0] a;
    logic [31:0] wd, word, rd, wlane;
    logic [3:0] be;
    logic [7:0] byte_v;
    logic [15:0] half;
    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW+2];
    always_comb begin
        accept = state_q == IDLE && req_valid && !reset;
        state_d = state_q;
        cnt_d = cnt_q;
        if (accept) begin
            state_d = LATENCY == 1 ? RESP : WAIT;
            cnt_d = CW'(LATENCY - 1);
        end else if (state_q == WAIT) begin
            state_d = cnt_q == CW'(1) ? RESP : WAIT;
            cnt_d = cnt_q - 1'b1;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        commit = state_d == RESP && state_q != RESP;
        // With LATENCY==1 the commit happens on the accepting edge, so use the live request
        we = state_q == IDLE ? req_we : we_q;
        f3 = state_q == IDLE ? req_funct3 : f3_q;
        a = state_q == IDLE ? req_addr[AW+1:0] : addr_q;
        wd = state_q == IDLE ? req_wdata : wdata_q;
        word = mem[a[AW+1:2]];
        byte_v = word[8*a[1:0] +: 8];
        half = a[1] ? word[31:16] : word[15:0];
        rd = f3[1:0] == 2'b00 ? {{24{byte_v[7] & ~f3[2]}}, byte_v}
           : f3[1:0] == 2'b01 ? {{16{half[15] & ~f3[2]}}, half} : word;
        bad = we ? !(f3 == 3'b000 || (f3 == 3'b001 && !a[0]) || (f3 == 3'b010 && a[1:0] == 2'b00))
                 : !(f3[1:0] == 2'b00 || (f3[1:0] == 2'b01 && !a[0]) || (f3 == 3'b010 && a[1:0] == 2'b00));
        be = (bad || !we) ? 4'b0000 : f3 == 3'b000 ? 4'b0001 << a[1:0]
           : f3 == 3'b001 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wlane = f3 == 3'b000 ? {4{wd[7:0]}} : f3 == 3'b001 ? {2{wd[15:0]}} : wd;
        resp_rdata_d = commit ? ((bad || we) ? 32'd0 : rd) : resp_rdata_q;
        resp_err_d = commit ? bad : resp_err_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            we_q <= 1'b0;
            f3_q <= 3'd0;
            addr_q <= '0;
            wdata_q <= 32'd0;
            req_ready_q <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            if (accept) begin
                we_q <= req_we;
                f3_q <= req_funct3;
                addr_q <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
            end
            req_ready_q <= state_d == IDLE;
            resp_valid_q <= state_d == RESP;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q <= resp_err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (commit && !reset)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[a[AW+1:2]][8*i +: 8] <= wlane[8*i +: 8];
    end
    assign req_ready = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a byte-array memory model.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LATENCY = 2;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic req_we = 1'b0;
    logic [2:0] req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic resp_valid;
    logic [31:0] resp_rdata;
    logic resp_err;
    int checks = 0;
    int errors = 0;
    logic [7:0] mb [4*DEPTH];
    logic [31:0] got_r;
    logic got_e;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] r, output logic e);
        int sz;
        int base;
        sz = we ? (f3 == 0 ? 1 : f3 == 1 ? 2 : f3 == 2 ? 4 : 0)
                : ((f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : f3 == 2 ? 4 : 0);
        e = sz == 0 || (int'(addr[1:0]) % sz) != 0;
        base = int'(addr % (4 * DEPTH));
        r = 32'd0;
        if (!e && we)
            for (int i = 0; i < sz; i++) mb[base + i] = wd[8*i +: 8];
        if (!e && !we) begin
            for (int i = 0; i < sz; i++) r = r | (32'(mb[base + i]) << (8 * i));
            if (f3 < 4 && sz < 4 && r[8*sz-1]) r = r | (32'hFFFF_FFFF << (8 * sz));
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string name);
        logic [31:0] er;
        logic ee;
        int w;
        int hit;
        model(we, f3, addr, wd, er, ee);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 20) begin
            errors++;
            $display("FAIL %s ready_timeout: req_ready=%b, required 1", name, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        hit = 0;
        for (int n = 1; n <= LATENCY + 1; n++) begin
            if (n > 1) @(negedge clk);
            if (resp_valid === 1'b1 && hit == 0) begin
                hit = n;
                got_r = resp_rdata;
                got_e = resp_err;
            end
        end
        checks++;
        if (hit !== LATENCY) begin
            errors++;
            $display("FAIL %s latency: resp_valid seen at cycle %0d, required %0d", name, hit, LATENCY);
        end
        checks++;
        if (got_r !== er) begin
            errors++;
            $display("FAIL %s rdata: got %h, required %h", name, got_r, er);
        end
        checks++;
        if (got_e !== ee) begin
            errors++;
            $display("FAIL %s err: got %b, required %b", name, got_e, ee);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks += 4;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", req_ready); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", resp_valid); end
        if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", resp_rdata); end
        if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", resp_err); end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
        do_req(0, 3'b010, 32'h10, 32'h0, "lw_10");
        checks++;
        if (got_r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_10_const: got %h, required deadbeef", got_r); end
        do_req(1, 3'b000, 32'h13, 32'h80, "sb_13");
        do_req(0, 3'b000, 32'h13, 32'h0, "lb_13");
        checks++;
        if (got_r !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_13_const: got %h, required ffffff80", got_r); end
        do_req(0, 3'b100, 32'h13, 32'h0, "lbu_13");
        do_req(0, 3'b010, 32'h10, 32'h0, "lw_10_b");
        checks++;
        if (got_r !== 32'h80ADBEEF) begin errors++; $display("FAIL lw_10_b_const: got %h, required 80adbeef", got_r); end
        do_req(1, 3'b001, 32'h12, 32'h1234, "sh_12");
        do_req(0, 3'b010, 32'h10, 32'h0, "lw_10_c");
        checks++;
        if (got_r !== 32'h1234BEEF) begin errors++; $display("FAIL lw_10_c_const: got %h, required 1234beef", got_r); end
        do_req(0, 3'b101, 32'h12, 32'h0, "lhu_12");
        do_req(0, 3'b001, 32'h11, 32'h0, "lh_11_misaligned");
        checks++;
        if (got_e !== 1'b1 || got_r !== 32'd0) begin errors++; $display("FAIL lh_11_const: got err=%b rdata=%h, required err=1 rdata=0", got_e, got_r); end
        do_req(1, 3'b010, 32'h0, 32'h11223344, "sw_00");
        do_req(1, 3'b010, 32'h3, 32'hFFFFFFFF, "sw_03_misaligned");
        do_req(0, 3'b010, 32'h0, 32'h0, "lw_00");
        checks++;
        if (got_r !== 32'h11223344) begin errors++; $display("FAIL lw_00_const: got %h, required 11223344", got_r); end
        do_req(0, 3'b011, 32'h0, 32'h0, "load_f3_011");
        do_req(1, 3'b011, 32'h0, 32'h0, "store_f3_011");
        do_req(1, 3'b010, 32'h400, 32'hA5A5A5A5, "sw_400_alias");
        do_req(0, 3'b010, 32'h0, 32'h0, "lw_00_alias");
        checks++;
        if (got_r !== 32'hA5A5A5A5) begin errors++; $display("FAIL lw_alias_const: got %h, required a5a5a5a5", got_r); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic [31:0] er;
        logic ee;
        model(0, 3'b010, 32'h10, 32'h0, er, ee);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            checks += 2;
            if (req_ready !== (c % 3 == 0)) begin errors++; $display("FAIL b2b_ready c=%0d: got %b, required %b", c, req_ready, c % 3 == 0); end
            if (resp_valid !== (c % 3 == 2)) begin errors++; $display("FAIL b2b_valid c=%0d: got %b, required %b", c, resp_valid, c % 3 == 2); end
            if (resp_valid === 1'b1) begin
                pulses++;
                checks++;
                if (resp_rdata !== er) begin errors++; $display("FAIL b2b_rdata c=%0d: got %h, required %h", c, resp_rdata, er); end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d, required 4", pulses); end
    endtask

    task automatic test_reset_mid_wait();
        do_req(1, 3'b010, 32'h20, 32'h00000055, "sw_20_prior");
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h99999999; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b, required 1", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) reset = 1'b0;
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid c=%0d: got %b, required 0", c, resp_valid); end
        end
        do_req(0, 3'b010, 32'h20, 32'h0, "lw_20_after_reset");
        checks++;
        if (got_r !== 32'h00000055) begin errors++; $display("FAIL lw_20_const: got %h, required 00000055", got_r); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) do_req(1, 3'b010, 32'(i * 4), $urandom, "rand_init");
        for (int i = 0; i < 60; i++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   {22'($urandom), 4'd0, 6'($urandom_range(0, 63))}, $urandom, "rand_op");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
